// File: rtl/bsg_rotate_pkg.sv
// Shared types and helpers for the pipelined rotate/shift block.
// Left modes are realised as bit-reverse / right-op / bit-reverse.
package bsg_rotate_pkg;

  typedef enum logic [1:0] {
    ROR = 2'd0,
    ROL = 2'd1,
    SRL = 2'd2,
    SLL = 2'd3
  } bsg_rotate_mode_e;

  // Widest word the bit-reverse helper handles; callers size-cast in and out.
  localparam int max_width_lp = 256;

  function automatic logic [max_width_lp-1:0] bsg_rotate_bitrev(
    input logic [max_width_lp-1:0] x,
    input int                      w
  );
    logic [max_width_lp-1:0] r;
    r = '0;
    for (int i = 0; i < max_width_lp; i++) begin
      if (i < w) r[i] = x[w-1-i];
    end
    return r;
  endfunction

  function automatic logic bsg_rotate_is_left(input logic [1:0] m);
    return (m == ROL) || (m == SLL);
  endfunction

  function automatic logic bsg_rotate_is_shift(input logic [1:0] m);
    return (m == SRL) || (m == SLL);
  endfunction

endpackage

// File: rtl/bsg_rotate_stage.sv
// Combinational group of right-rotate/right-shift log-shifter levels.
// Level first_level_p+i moves the word by 2^(first_level_p+i) when that amt bit is set.
module bsg_rotate_stage #(
  parameter int width_p       = 16,
  parameter int first_level_p = 0,
  parameter int num_levels_p  = 1,
  localparam int lg_width_lp  = $clog2(width_p)
) (
  input  logic [width_p-1:0]     data_i,
  input  logic [lg_width_lp-1:0] amt_i,
  input  logic                   zero_fill_i,
  output logic [width_p-1:0]     data_o
);

  logic [num_levels_p:0][width_p-1:0] lvl;

  assign lvl[0] = data_i;

  for (genvar i = 0; i < num_levels_p; i++) begin : g_level
    localparam int dist_lp = 1 << (first_level_p + i);
    logic [width_p-1:0] moved;

    assign moved = zero_fill_i ? (lvl[i] >> dist_lp)
                               : ((lvl[i] >> dist_lp) | (lvl[i] << (width_p - dist_lp)));
    assign lvl[i+1] = amt_i[first_level_p+i] ? moved : lvl[i];
  end

  assign data_o = lvl[num_levels_p];

  // Amount bits outside this stage's levels belong to other stages.
  logic unused_amt;
  assign unused_amt = ^{amt_i, zero_fill_i};

endmodule

// File: rtl/bsg_rotate_pipe.sv
// Pipelined rotate/shift, stages_p cycles latency, valid/ready in and valid/yumi out.
// Bubbles collapse; ready_o is combinational from yumi_i through the stage chain.
module bsg_rotate_pipe
  import bsg_rotate_pkg::*;
#(
  parameter int width_p      = 16,
  parameter int stages_p     = 2,
  localparam int lg_width_lp = $clog2(width_p)
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   v_i,
  output logic                   ready_o,
  input  logic [width_p-1:0]     data_i,
  input  logic [lg_width_lp-1:0] amt_i,
  input  logic [1:0]             mode_i,
  output logic                   v_o,
  output logic [width_p-1:0]     data_o,
  input  logic                   yumi_i
);

  localparam int levels_per_stage_lp = (lg_width_lp + stages_p - 1) / stages_p;

  logic [stages_p-1:0]                  v_q;
  logic [stages_p-1:0]                  load;
  logic [stages_p-1:0][width_p-1:0]     data_q;
  logic [stages_p-1:0][lg_width_lp-1:0] amt_q;
  logic [stages_p-1:0][1:0]             mode_q;
  logic [width_p-1:0]                   entry_data;
  logic [width_p-1:0]                   last_data;
  logic [1:0]                           last_mode;

  assign entry_data = bsg_rotate_is_left(mode_i)
                    ? width_p'(bsg_rotate_bitrev(max_width_lp'(data_i), width_p))
                    : data_i;

  // Walk from the tail: a stage can load if it is empty or its word is leaving.
  always_comb begin
    logic nxt;
    load = '0;
    nxt  = yumi_i;
    for (int k = stages_p - 1; k >= 0; k--) begin
      load[k] = ~v_q[k] | (v_q[k] & nxt);
      nxt     = load[k];
    end
  end

  assign ready_o = load[0];

  for (genvar k = 0; k < stages_p; k++) begin : g_stage
    localparam int first_lp = (k * levels_per_stage_lp < lg_width_lp)
                            ? k * levels_per_stage_lp : lg_width_lp;
    localparam int num_lp   = (lg_width_lp - first_lp < levels_per_stage_lp)
                            ? lg_width_lp - first_lp : levels_per_stage_lp;

    logic                   v_in;
    logic [width_p-1:0]     sh_in;
    logic [width_p-1:0]     sh_out;
    logic [lg_width_lp-1:0] amt_in;
    logic [1:0]             mode_in;
    logic                   v_r;
    logic [width_p-1:0]     data_r;
    logic [lg_width_lp-1:0] amt_r;
    logic [1:0]             mode_r;

    if (k == 0) begin : g_head
      assign v_in    = v_i;
      assign sh_in   = entry_data;
      assign amt_in  = amt_i;
      assign mode_in = mode_i;
    end else begin : g_body
      assign v_in    = v_q[k-1];
      assign sh_in   = data_q[k-1];
      assign amt_in  = amt_q[k-1];
      assign mode_in = mode_q[k-1];
    end

    bsg_rotate_stage #(
      .width_p      (width_p),
      .first_level_p(first_lp),
      .num_levels_p (num_lp)
    ) u_stage (
      .data_i     (sh_in),
      .amt_i      (amt_in),
      .zero_fill_i(bsg_rotate_is_shift(mode_in)),
      .data_o     (sh_out)
    );

    always_ff @(posedge clk_i) begin
      if (reset_i) begin
        v_r <= 1'b0;
      end else if (load[k]) begin
        v_r <= v_in;
      end
      if (load[k] & v_in) begin
        data_r <= sh_out;
        amt_r  <= amt_in;
        mode_r <= mode_in;
      end
    end

    assign v_q[k]    = v_r;
    assign data_q[k] = data_r;
    assign amt_q[k]  = amt_r;
    assign mode_q[k] = mode_r;
  end

  assign last_data = data_q[stages_p-1];
  assign last_mode = mode_q[stages_p-1];
  assign v_o       = v_q[stages_p-1];
  assign data_o    = bsg_rotate_is_left(last_mode)
                   ? width_p'(bsg_rotate_bitrev(max_width_lp'(last_data), width_p))
                   : last_data;

  // The tail's amount has been fully consumed by the time it is registered.
  logic unused_amt_tail;
  assign unused_amt_tail = ^amt_q[stages_p-1];

  always_ff @(posedge clk_i) begin
    if (!reset_i && yumi_i) assert (v_o);
  end

endmodule

// File: tb/tb_bsg_rotate_pipe.sv
// Directed checks on a 16-bit/2-stage pipe plus random sweeps of 32-bit pipes at 1 and 4 stages.
module tb_bsg_rotate_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic        rst16 = 1'b1, v16 = 1'b0, yumi16 = 1'b0, ready16, vo16;
  logic [15:0] di16 = '0, do16;
  logic [3:0]  amt16 = '0;
  logic [1:0]  mode16 = '0;

  logic        rst32 = 1'b1;
  logic        v_a = 1'b0, yumi_a = 1'b0, ready_a, vo_a;
  logic [31:0] di_a = '0, do_a;
  logic [4:0]  amt_a = '0;
  logic [1:0]  mode_a = '0;
  logic        v_b = 1'b0, yumi_b = 1'b0, ready_b, vo_b;
  logic [31:0] di_b = '0, do_b;
  logic [4:0]  amt_b = '0;
  logic [1:0]  mode_b = '0;

  logic [31:0] qa[$];
  logic [31:0] qb[$];

  bsg_rotate_pipe #(.width_p(16), .stages_p(2)) dut16 (
    .clk_i(clk), .reset_i(rst16), .v_i(v16), .ready_o(ready16), .data_i(di16),
    .amt_i(amt16), .mode_i(mode16), .v_o(vo16), .data_o(do16), .yumi_i(yumi16));

  bsg_rotate_pipe #(.width_p(32), .stages_p(1)) dut_a (
    .clk_i(clk), .reset_i(rst32), .v_i(v_a), .ready_o(ready_a), .data_i(di_a),
    .amt_i(amt_a), .mode_i(mode_a), .v_o(vo_a), .data_o(do_a), .yumi_i(yumi_a));

  bsg_rotate_pipe #(.width_p(32), .stages_p(4)) dut_b (
    .clk_i(clk), .reset_i(rst32), .v_i(v_b), .ready_o(ready_b), .data_i(di_b),
    .amt_i(amt_b), .mode_i(mode_b), .v_o(vo_b), .data_o(do_b), .yumi_i(yumi_b));

  function automatic logic [31:0] model(input int w, input logic [31:0] d, input int a, input logic [1:0] m);
    logic [63:0] x, mask, r;
    mask = (64'd1 << w) - 64'd1;
    x    = {32'd0, d} & mask;
    case (m)
      2'd0:    r = (x >> a) | (x << (w - a));
      2'd1:    r = (x << a) | (x >> (w - a));
      2'd2:    r = x >> a;
      default: r = x << a;
    endcase
    return 32'(r & mask);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send16(input string tag, input logic [15:0] d, input logic [3:0] a,
                        input logic [1:0] m, input logic [15:0] exp);
    v16 = 1'b1; di16 = d; amt16 = a; mode16 = m;
    #1;
    chk({tag, " ready"}, ready16, 1);
    tick();
    v16 = 1'b0;
    #1;
    chk({tag, " v_o cycle1"}, vo16, 0);
    tick();
    chk({tag, " v_o cycle2"}, vo16, 1);
    chk({tag, " data"}, do16, exp);
    yumi16 = 1'b1;
    tick();
    yumi16 = 1'b0;
    chk({tag, " drained"}, vo16, 0);
  endtask

  initial begin
    int cnt;

    // Reset
    repeat (3) tick();
    chk("reset v_o16", vo16, 0);
    chk("reset v_o_a", vo_a, 0);
    chk("reset v_o_b", vo_b, 0);
    rst16 = 1'b0; rst32 = 1'b0;
    #1;
    chk("reset ready16", ready16, 1);
    chk("reset ready_a", ready_a, 1);
    chk("reset ready_b", ready_b, 1);
    tick();

    // Directed single words
    send16("ror 0001 by 1",  16'h0001, 4'd1,  2'd0, 16'h8000);
    send16("rol 8001 by 4",  16'h8001, 4'd4,  2'd1, 16'h0018);
    send16("sll 00ff by 8",  16'h00FF, 4'd8,  2'd3, 16'hFF00);
    send16("srl 8000 by 15", 16'h8000, 4'd15, 2'd2, 16'h0001);
    send16("srl f000 by 12", 16'hF000, 4'd12, 2'd2, 16'h000F);
    send16("rol 1234 by 0",  16'h1234, 4'd0,  2'd1, 16'h1234);
    send16("ror 8001 by 15", 16'h8001, 4'd15, 2'd0, 16'h0003);

    // Streaming: consumer always takes whatever is valid
    for (int c = 0; c < 18; c++) begin
      yumi16 = vo16;
      v16 = (c < 16); di16 = 16'hA5C3; amt16 = 4'(c); mode16 = 2'd0;
      #1;
      if (c < 16) chk("stream ready", ready16, 1);
      if (c >= 2) begin
        chk("stream v_o", vo16, 1);
        chk("stream data", do16, model(16, 32'h0000A5C3, c - 2, 2'd0));
      end else begin
        chk("stream fill v_o", vo16, 0);
      end
      tick();
    end
    yumi16 = 1'b0; v16 = 1'b0;
    #1;
    chk("stream empty", vo16, 0);
    tick();

    // Backpressure: capacity two words
    v16 = 1'b1; di16 = 16'h1234; amt16 = 4'd4; mode16 = 2'd0;
    #1; chk("bp ready w0", ready16, 1); tick();
    mode16 = 2'd3;
    #1; chk("bp ready w1", ready16, 1); tick();
    mode16 = 2'd1;
    #1;
    chk("bp full ready", ready16, 0);
    chk("bp head valid", vo16, 1);
    chk("bp head data", do16, 16'h4123);
    tick();
    chk("bp still full", ready16, 0);
    yumi16 = 1'b1;
    #1;
    chk("bp release ready", ready16, 1);
    chk("bp out w0", do16, 16'h4123);
    tick();
    v16 = 1'b0;
    chk("bp v_o w1", vo16, 1);
    chk("bp out w1", do16, 16'h2340);
    tick();
    chk("bp v_o w2", vo16, 1);
    chk("bp out w2", do16, 16'h2341);
    tick();
    yumi16 = 1'b0;
    chk("bp drained", vo16, 0);

    // Reset with two words in flight
    v16 = 1'b1; di16 = 16'h00F0; amt16 = 4'd4; mode16 = 2'd0;
    tick();
    di16 = 16'h0F00;
    tick();
    v16 = 1'b0;
    #1;
    chk("rst pipe full", ready16, 0);
    rst16 = 1'b1;
    tick();
    chk("rst v_o", vo16, 0);
    rst16 = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("rst no stale", vo16, 0);
      chk("rst ready", ready16, 1);
      tick();
    end
    send16("post rst", 16'h00F0, 4'd4, 2'd0, 16'h000F);

    // Latency on idle 32-bit pipes
    v_a = 1'b1; di_a = 32'h8000_0001; amt_a = 5'd31; mode_a = 2'd1;
    #1; chk("lat a ready", ready_a, 1);
    tick(); v_a = 1'b0; cnt = 1;
    while (!vo_a && cnt < 10) begin tick(); cnt++; end
    chk("lat a cycles", cnt, 1);
    chk("lat a data", do_a, 32'hC000_0000);
    yumi_a = 1'b1; tick(); yumi_a = 1'b0;

    v_b = 1'b1; di_b = 32'h0000_FFFF; amt_b = 5'd20; mode_b = 2'd3;
    #1; chk("lat b ready", ready_b, 1);
    tick(); v_b = 1'b0; cnt = 1;
    while (!vo_b && cnt < 10) begin tick(); cnt++; end
    chk("lat b cycles", cnt, 4);
    chk("lat b data", do_b, 32'hFFF0_0000);
    yumi_b = 1'b1; tick(); yumi_b = 1'b0;

    // Random sweep against the reference model, then drain
    for (int c = 0; c < 400; c++) begin
      yumi_a = vo_a && ((c >= 380) || ($urandom_range(0, 3) != 0));
      yumi_b = vo_b && ((c >= 380) || ($urandom_range(0, 3) != 0));
      if (yumi_a) begin
        chk("sweep a nonempty", qa.size() > 0, 1);
        if (qa.size() > 0) chk("sweep a data", do_a, qa.pop_front());
      end
      if (yumi_b) begin
        chk("sweep b nonempty", qb.size() > 0, 1);
        if (qb.size() > 0) chk("sweep b data", do_b, qb.pop_front());
      end
      v_a = (c < 380) && ($urandom_range(0, 3) != 0);
      di_a = $urandom; amt_a = 5'($urandom_range(0, 31)); mode_a = 2'($urandom_range(0, 3));
      v_b = (c < 380) && ($urandom_range(0, 3) != 0);
      di_b = $urandom; amt_b = 5'($urandom_range(0, 31)); mode_b = 2'($urandom_range(0, 3));
      #1;
      if (v_a && ready_a) qa.push_back(model(32, di_a, int'(amt_a), mode_a));
      if (v_b && ready_b) qb.push_back(model(32, di_b, int'(amt_b), mode_b));
      tick();
    end
    yumi_a = 1'b0; yumi_b = 1'b0; v_a = 1'b0; v_b = 1'b0;
    chk("sweep a drained", qa.size(), 0);
    chk("sweep b drained", qb.size(), 0);
    chk("sweep a idle", vo_a, 0);
    chk("sweep b idle", vo_b, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
